// File: rtl/level_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// level_sequencer_pkg
// Shared game constants: sequencer state encoding and level range. The
// background and char drawers import the same level constants so that
// every consumer agrees on the first and last playable level.
// -----------------------------------------------------------------------------
package level_sequencer_pkg;

    // 3-bit phase encoding; codes 6 and 7 are unused and recover to ST_IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTRO = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } seq_state_e;

    localparam int unsigned MAX_LEVEL_DEF = 3;
    localparam logic [3:0]  LEVEL_FIRST   = 4'd1;

endpackage

// File: rtl/level_sequencer_if.sv
// -----------------------------------------------------------------------------
// level_sequencer_if
// Bundles the gameplay status pulses (start, enemies_cleared, player_dead)
// and the sequencer outputs (level, play_en, banner_on, game_over, win).
//   master : gameplay side, drives the pulses and observes the outputs
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface level_sequencer_if;

    logic       start;
    logic       enemies_cleared;
    logic       player_dead;
    logic [3:0] level;
    logic       play_en;
    logic       banner_on;
    logic       game_over;
    logic       win;

    modport master (
        output start, enemies_cleared, player_dead,
        input  level, play_en, banner_on, game_over, win
    );

    modport slave (
        input  start, enemies_cleared, player_dead,
        output level, play_en, banner_on, game_over, win
    );

endinterface

// File: rtl/level_sequencer_frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick
// One-pclk pulse on each vsync rising edge.
//   pclk     : pixel clock
//   rst      : synchronous active-high reset
//   vsync_in : vertical sync from the timing chain
//   tick     : high for one pclk per frame
// The delay flop resets to 1 so a vsync that is already high when reset is
// released does not produce a spurious tick.
// -----------------------------------------------------------------------------
module frame_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_d_r;

    // delayed copy of vsync for edge detection
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_d_r <= 1'b1;
        end else begin
            vsync_d_r <= vsync_in;
        end
    end

    assign tick = vsync_in & ~vsync_d_r;

endmodule

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Game-phase controller: IDLE -> INTRO -> PLAY -> CLEAR -> (INTRO | WIN),
// PLAY -> OVER, OVER/WIN -> IDLE on start. Phases are timed in frames.
//   pclk     : pixel clock
//   rst      : synchronous active-high reset
//   vsync_in : vertical sync; each rising edge is one frame
//   bus      : status pulses in, level/play_en/banner_on/game_over/win out
// All outputs are registered from the next-state values, so they show the
// new phase one pclk after the causing pulse or frame tick.
// -----------------------------------------------------------------------------
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEF,
    parameter int unsigned INTRO_FRAMES = 120,
    parameter int unsigned CLEAR_FRAMES = 90,
    parameter int unsigned FCNT_W       = 8
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync_in,
    level_sequencer_if.slave   bus
);

    localparam logic [FCNT_W-1:0] INTRO_LAST = FCNT_W'(INTRO_FRAMES - 1);
    localparam logic [FCNT_W-1:0] CLEAR_LAST = FCNT_W'(CLEAR_FRAMES - 1);
    localparam logic [3:0]        LEVEL_LAST = 4'(MAX_LEVEL);

    seq_state_e        state_r, next_state_s;
    logic [3:0]        level_r, next_level_s;
    logic [FCNT_W-1:0] cnt_r,   next_cnt_s;
    logic              play_en_r, banner_on_r, game_over_r, win_r;
    logic              tick_s;

    frame_tick u_frame_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .tick     (tick_s)
    );

    // state, level, counter and phase-flag registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            level_r     <= LEVEL_FIRST;
            cnt_r       <= '0;
            play_en_r   <= 1'b0;
            banner_on_r <= 1'b0;
            game_over_r <= 1'b0;
            win_r       <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            level_r     <= next_level_s;
            cnt_r       <= next_cnt_s;
            play_en_r   <= (next_state_s == ST_PLAY);
            banner_on_r <= (next_state_s == ST_INTRO) || (next_state_s == ST_CLEAR);
            game_over_r <= (next_state_s == ST_OVER);
            win_r       <= (next_state_s == ST_WIN);
        end
    end

    // next-state, level and frame-counter logic
    always_comb begin
        next_state_s = state_r;
        next_level_s = level_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                next_level_s = LEVEL_FIRST;
                if (bus.start) begin
                    next_state_s = ST_INTRO;
                    next_cnt_s   = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INTRO: begin
                if (tick_s) begin
                    if (cnt_r == INTRO_LAST) begin
                        next_state_s = ST_PLAY;
                        next_cnt_s   = '0;
                    end else begin
                        next_cnt_s   = cnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            ST_PLAY: begin
                // a death in the same cycle as the clear takes priority
                if (bus.player_dead) begin
                    next_state_s = ST_OVER;
                    next_cnt_s   = '0;
                end else if (bus.enemies_cleared) begin
                    next_state_s = ST_CLEAR;
                    next_cnt_s   = '0;
                end else begin
                    next_state_s = ST_PLAY;
                end
            end
            ST_CLEAR: begin
                if (tick_s) begin
                    if (cnt_r == CLEAR_LAST) begin
                        next_cnt_s = '0;
                        if (level_r == LEVEL_LAST) begin
                            next_state_s = ST_WIN;
                        end else begin
                            next_state_s = ST_INTRO;
                            next_level_s = level_r + 4'd1;
                        end
                    end else begin
                        next_cnt_s = cnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            ST_OVER, ST_WIN: begin
                if (bus.start) begin
                    next_state_s = ST_IDLE;
                    next_level_s = LEVEL_FIRST;
                    next_cnt_s   = '0;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_level_s = LEVEL_FIRST;
                next_cnt_s   = '0;
            end
        endcase
    end

    assign bus.level     = level_r;
    assign bus.play_en   = play_en_r;
    assign bus.banner_on = banner_on_r;
    assign bus.game_over = game_over_r;
    assign bus.win       = win_r;

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
// Directed bench for level_sequencer with INTRO_FRAMES=2, CLEAR_FRAMES=2,
// MAX_LEVEL=3. Inputs change on the falling edge; outputs are checked on
// the following falling edge, after the rising edge has registered them.
// -----------------------------------------------------------------------------
module tb_level_sequencer;

    logic pclk;
    logic rst;
    logic vsync_in;
    int   n_tests;
    int   n_fail;

    level_sequencer_if ifc ();

    level_sequencer #(
        .MAX_LEVEL    (3),
        .INTRO_FRAMES (2),
        .CLEAR_FRAMES (2),
        .FCNT_W       (8)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .bus      (ifc)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // count one comparison and report it if it differs
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // all outputs at once: level, play_en, banner_on, game_over, win
    task automatic check_outs(input string tag, input int lvl, input int pe,
                              input int bn, input int go, input int wn);
        check_val({tag, ".level"},     32'(ifc.level),     32'(lvl));
        check_val({tag, ".play_en"},   32'(ifc.play_en),   32'(pe));
        check_val({tag, ".banner_on"}, 32'(ifc.banner_on), 32'(bn));
        check_val({tag, ".game_over"}, 32'(ifc.game_over), 32'(go));
        check_val({tag, ".win"},       32'(ifc.win),       32'(wn));
    endtask

    task automatic pulse_start();
        @(negedge pclk) ifc.start = 1'b1;
        @(negedge pclk) ifc.start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge pclk) ifc.enemies_cleared = 1'b1;
        @(negedge pclk) ifc.enemies_cleared = 1'b0;
    endtask

    // one full vsync period: one rising edge
    task automatic frame();
        @(negedge pclk) vsync_in = 1'b1;
        repeat (2) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst                 = 1'b1;
        vsync_in            = 1'b1;
        ifc.start           = 1'b0;
        ifc.enemies_cleared = 1'b0;
        ifc.player_dead     = 1'b0;

        // reset with vsync held high through release
        repeat (3) @(negedge pclk);
        check_outs("reset", 1, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        check_outs("idle", 1, 0, 0, 0, 0);

        // start -> INTRO level 1
        pulse_start();
        check_outs("intro1", 1, 0, 1, 0, 0);
        @(negedge pclk) vsync_in = 1'b0;
        repeat (2) @(negedge pclk);
        check_outs("intro_no_tick", 1, 0, 1, 0, 0);
        frame();
        check_outs("intro_1frame", 1, 0, 1, 0, 0);
        pulse_start();
        pulse_clear();
        check_outs("intro_ignore", 1, 0, 1, 0, 0);
        frame();
        check_outs("play1", 1, 1, 0, 0, 0);

        // level 1 clear -> level 2
        pulse_start();
        check_outs("play_ignore_start", 1, 1, 0, 0, 0);
        pulse_clear();
        check_outs("clear1", 1, 0, 1, 0, 0);
        frame();
        check_outs("clear1_1frame", 1, 0, 1, 0, 0);
        frame();
        check_outs("intro2", 2, 0, 1, 0, 0);
        frames(2);
        check_outs("play2", 2, 1, 0, 0, 0);

        // level 2 and 3 clears -> WIN
        pulse_clear();
        frames(2);
        check_outs("intro3", 3, 0, 1, 0, 0);
        frames(2);
        check_outs("play3", 3, 1, 0, 0, 0);
        pulse_clear();
        check_outs("clear3", 3, 0, 1, 0, 0);
        frames(2);
        check_outs("win", 3, 0, 0, 0, 1);
        frame();
        check_outs("win_hold", 3, 0, 0, 0, 1);
        pulse_start();
        check_outs("win_to_idle", 1, 0, 0, 0, 0);
        pulse_clear();
        check_outs("idle_ignore", 1, 0, 0, 0, 0);

        // simultaneous clear and death -> OVER
        pulse_start();
        frames(2);
        check_outs("play_b", 1, 1, 0, 0, 0);
        @(negedge pclk);
        ifc.enemies_cleared = 1'b1;
        ifc.player_dead     = 1'b1;
        @(negedge pclk);
        ifc.enemies_cleared = 1'b0;
        ifc.player_dead     = 1'b0;
        check_outs("over", 1, 0, 0, 1, 0);
        frames(2);
        check_outs("over_hold", 1, 0, 0, 1, 0);
        pulse_start();
        check_outs("over_to_idle", 1, 0, 0, 0, 0);

        // reach CLEAR at level 2, then reset mid-phase with vsync rising
        pulse_start();
        frames(2);
        pulse_clear();
        frames(2);
        frames(2);
        pulse_clear();
        frame();
        check_outs("clear2", 2, 0, 1, 0, 0);
        @(negedge pclk);
        rst      = 1'b1;
        vsync_in = 1'b1;
        @(negedge pclk) rst = 1'b0;
        check_outs("mid_reset", 1, 0, 0, 0, 0);
        repeat (2) @(negedge pclk);
        pulse_start();
        @(negedge pclk) vsync_in = 1'b0;
        @(negedge pclk);
        frame();
        check_outs("post_reset_cnt", 1, 0, 1, 0, 0);
        frame();
        check_outs("post_reset_play", 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
